// File: rtl/selfadd_pkg.sv
// Shared definitions for the self-add accumulator result path.
package selfadd_pkg;

    // Width of one accumulated sum.
    localparam int unsigned DATA_W = 16;
    // One (a, b) pair as packed into an output word.
    localparam int unsigned PAIR_W = 2 * DATA_W;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/selfadd_word_fifo.sv
// First-word-fall-through FIFO for packed result words.
// The caller guarantees push only when not full (or full with a same-cycle pop)
// and pop only when not empty.
module selfadd_word_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write; full+push+pop overwrites the slot being popped, which is safe
    // because the old head is read before the edge.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    // Gate the head so an empty FIFO presents zero instead of stale storage.
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/selfadd_result_packer.sv
// Packs PACK_N consecutive (a, b) accumulator results into one wide word and
// buffers words in a FWFT FIFO with valid/ready output and a halt back-channel.
// Optional build macro: SELFADD_PACK_RELU_EN clamps negative sums to zero before packing.
module selfadd_result_packer
    import selfadd_pkg::*;
#(
    parameter int unsigned PACK_N     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             usr_rst,
    input  logic [DATA_W-1:0]                in_data_a,
    input  logic [DATA_W-1:0]                in_data_b,
    input  logic                             in_v,
    output logic                             halt,
    output logic [PACK_N*PAIR_W-1:0]         out_data,
    output logic                             out_v,
    input  logic                             out_rdy,
    output logic                             ovf,
    output logic [fill_w(FIFO_DEPTH)-1:0]    fill
);

    localparam int unsigned FILL_W = fill_w(FIFO_DEPTH);
    localparam int unsigned WORD_W = PACK_N * PAIR_W;
    localparam int unsigned CNT_W  = $clog2(PACK_N);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PACK_N - 1);

    function automatic logic [DATA_W-1:0] clamp_sum(input logic [DATA_W-1:0] sum);
`ifdef SELFADD_PACK_RELU_EN
        return sum[DATA_W-1] ? '0 : sum;
`else
        return sum;
`endif
    endfunction

    logic [WORD_W-1:0] r_pack;
    logic [CNT_W-1:0]  r_pack_cnt;
    logic              r_ovf;

    logic [WORD_W-1:0] w_pack_nxt;
    logic [CNT_W-1:0]  w_pack_cnt_nxt;
    logic              w_ovf_nxt;
    logic [PAIR_W-1:0] w_pair;
    logic [WORD_W-1:0] w_word;
    logic              w_last;
    logic              w_pop;
    logic              w_push;
    logic              w_can_push;
    logic              w_full;
    logic              w_empty;
    logic [FILL_W-1:0] w_count;

    assign w_pair     = {clamp_sum(in_data_b), clamp_sum(in_data_a)};
    assign w_last     = (r_pack_cnt == LAST_SLOT);
    assign w_pop      = ~w_empty & out_rdy & ~usr_rst;
    assign w_can_push = ~w_full | w_pop;
    assign w_push     = in_v & w_last & w_can_push & ~usr_rst;

    // Completed word: partial pack with the incoming pair in the top slot.
    always_comb begin
        w_word = r_pack;
        w_word[(PACK_N-1)*PAIR_W +: PAIR_W] = w_pair;
    end

    // Next-state for the pack register, slot counter and sticky overflow.
    always_comb begin
        w_pack_nxt     = r_pack;
        w_pack_cnt_nxt = r_pack_cnt;
        w_ovf_nxt      = r_ovf;
        if (usr_rst) begin
            w_pack_nxt     = '0;
            w_pack_cnt_nxt = '0;
            w_ovf_nxt      = 1'b0;
        end else if (in_v) begin
            if (!w_last) begin
                w_pack_nxt[int'(r_pack_cnt)*PAIR_W +: PAIR_W] = w_pair;
                w_pack_cnt_nxt = r_pack_cnt + CNT_W'(1);
            end else if (w_can_push) begin
                w_pack_nxt     = '0;
                w_pack_cnt_nxt = '0;
            end else begin
                // No room: drop the pair, keep the partial word intact.
                w_ovf_nxt = 1'b1;
            end
        end
    end

    // Pack state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pack     <= '0;
            r_pack_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_pack     <= w_pack_nxt;
            r_pack_cnt <= w_pack_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    selfadd_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (usr_rst),
        .push      (w_push),
        .push_data (w_word),
        .pop       (w_pop),
        .head_data (out_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Halt one slot early: the next final pair would need the last free entry.
    assign halt  = (w_count == FILL_W'(FIFO_DEPTH)) |
                   ((w_count == FILL_W'(FIFO_DEPTH - 1)) & w_last);
    assign out_v = ~w_empty;
    assign ovf   = r_ovf;
    assign fill  = w_count;

endmodule

// File: tb/tb_selfadd_result_packer.sv
// Self-checking bench for selfadd_result_packer with a queue-based reference model.
module tb_selfadd_result_packer;

    localparam int unsigned PN = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned FW = $clog2(FD) + 1;
    localparam int unsigned W  = PN * 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          usr_rst = 1'b0;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          in_v = 1'b0;
    logic          out_rdy = 1'b0;
    logic          halt;
    logic [W-1:0]  out_data;
    logic          out_v;
    logic          ovf;
    logic [FW-1:0] fill;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: pending pairs of the current word, queue of packed words.
    logic [31:0]   m_pend[$];
    logic [W-1:0]  m_q[$];
    logic          m_ovf = 1'b0;

    always #5 clk = ~clk;

    selfadd_result_packer #(
        .PACK_N     (PN),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .usr_rst   (usr_rst),
        .in_data_a (a),
        .in_data_b (b),
        .in_v      (in_v),
        .halt      (halt),
        .out_data  (out_data),
        .out_v     (out_v),
        .out_rdy   (out_rdy),
        .ovf       (ovf),
        .fill      (fill)
    );

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef SELFADD_PACK_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit           pop;
        bit           have_word;
        logic [W-1:0] word;
        logic [31:0]  pair;
        pop       = (m_q.size() != 0) && out_rdy;
        have_word = 1'b0;
        word      = '0;
        if (usr_rst) begin
            m_pend.delete();
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        if (in_v) begin
            pair = {relu(b), relu(a)};
            if (m_pend.size() < PN - 1) begin
                m_pend.push_back(pair);
            end else if (m_q.size() < FD || pop) begin
                for (int k = 0; k < PN - 1; k++) begin
                    word[k*32 +: 32] = m_pend[k];
                end
                word[(PN-1)*32 +: 32] = pair;
                have_word = 1'b1;
                m_pend.delete();
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (have_word) m_q.push_back(word);
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_d;
        bit           exp_halt;
        exp_d    = (m_q.size() != 0) ? m_q[0] : '0;
        exp_halt = (m_q.size() == FD) || (m_q.size() == FD - 1 && m_pend.size() == PN - 1);
        check({tag, ".out_v"}, W'(out_v), W'(m_q.size() != 0));
        check({tag, ".out_data"}, out_data, exp_d);
        check({tag, ".fill"}, W'(fill), W'(m_q.size()));
        check({tag, ".halt"}, W'(halt), W'(exp_halt));
        check({tag, ".ovf"}, W'(ovf), W'(m_ovf));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // One pair, then two idle cycles (legal upstream rate).
    task automatic feed(input logic [15:0] pa, input logic [15:0] pb, input string tag);
        a    = pa;
        b    = pb;
        in_v = 1'b1;
        step(tag);
        in_v = 1'b0;
        step(tag);
        step(tag);
    endtask

    initial begin
        // Reset / idle
        #1 rst = 1'b0;
        #10;
        check("rst.out_v", W'(out_v), W'(1'b0));
        check("rst.halt", W'(halt), W'(1'b0));
        check("rst.fill", W'(fill), W'(0));
        check("rst.ovf", W'(ovf), W'(1'b0));
        check("rst.out_data", out_data, '0);
        rst = 1'b1;
        step("idle");

        // Basic packing with out_rdy high
        out_rdy = 1'b1;
        feed(16'd1, 16'd2, "basic");
        feed(16'd3, 16'd4, "basic");
        feed(16'd5, 16'd6, "basic");
        a = 16'd7; b = 16'd8; in_v = 1'b1;
        step("basic.last");
        check("basic.word", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("basic.v1", W'(out_v), W'(1'b1));
        in_v = 1'b0;
        step("basic.pop");
        check("basic.v0", W'(out_v), W'(1'b0));

        // Back-pressure: 16 pairs into a stalled output
        out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            feed(16'($urandom), 16'($urandom), "bp");
            if (i == 11) check("bp.halt_lo", W'(halt), W'(1'b0));
            if (i == 14) begin
                check("bp.fill3", W'(fill), W'(3));
                check("bp.halt_hi", W'(halt), W'(1'b1));
            end
        end
        check("bp.fill4", W'(fill), W'(4));
        check("bp.halt_full", W'(halt), W'(1'b1));

        // Full FIFO, final pair arrives with a same-cycle pop
        for (int i = 0; i < 3; i++) feed(16'($urandom), 16'($urandom), "fpp.fill");
        a = 16'($urandom); b = 16'($urandom); in_v = 1'b1; out_rdy = 1'b1;
        step("fpp");
        check("fpp.fill", W'(fill), W'(4));
        check("fpp.ovf", W'(ovf), W'(1'b0));
        in_v = 1'b0; out_rdy = 1'b0;
        step("fpp.after");

        // Overflow: ignore halt with the FIFO full
        for (int i = 0; i < 5; i++) feed(16'($urandom), 16'($urandom), "ovf");
        check("ovf.set", W'(ovf), W'(1'b1));
        check("ovf.fill", W'(fill), W'(4));

        // Release back-pressure: words drain in order (model holds the order)
        out_rdy = 1'b1;
        repeat (6) step("drain");
        check("drain.empty", W'(out_v), W'(1'b0));
        check("drain.ovf_sticky", W'(ovf), W'(1'b1));

        // usr_rst overrides a same-cycle pair and pop
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) feed(16'($urandom), 16'($urandom), "ur.fill");
        a = 16'($urandom); b = 16'($urandom); in_v = 1'b1; out_rdy = 1'b1; usr_rst = 1'b1;
        step("ur");
        check("ur.fill", W'(fill), W'(0));
        check("ur.ovf", W'(ovf), W'(1'b0));
        check("ur.out_v", W'(out_v), W'(1'b0));
        in_v = 1'b0; usr_rst = 1'b0; out_rdy = 1'b0;
        step("ur.after");

        // Negative sum in the first slot
        feed(16'hFFFE, 16'h0005, "relu");
        for (int i = 0; i < 3; i++) feed(16'($urandom), 16'($urandom), "relu");
`ifdef SELFADD_PACK_RELU_EN
        check("relu.slot0", W'(out_data[31:0]), W'(32'h0005_0000));
`else
        check("relu.slot0", W'(out_data[31:0]), W'(32'h0005_FFFE));
`endif
        out_rdy = 1'b1;
        step("relu.drain");
        out_rdy = 1'b0;

        // Asynchronous reset between clock edges
        for (int i = 0; i < 6; i++) feed(16'($urandom), 16'($urandom), "ar.fill");
        rst = 1'b0;
        #3;
        check("ar.out_v", W'(out_v), W'(1'b0));
        check("ar.fill", W'(fill), W'(0));
        check("ar.halt", W'(halt), W'(1'b0));
        check("ar.out_data", out_data, '0);
        m_pend.delete();
        m_q.delete();
        m_ovf = 1'b0;
        rst = 1'b1;
        step("ar.after");

        // Random traffic, including halt violations and soft clears
        for (int i = 0; i < 400; i++) begin
            in_v    = ($urandom_range(0, 2) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            usr_rst = ($urandom_range(0, 59) == 0);
            a       = 16'($urandom);
            b       = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/selfadd_result_packer.md
# selfadd_result_packer

Downstream stage of the 16-bit×2 self-add accumulator unit. It captures each completed pair of accumulated sums (a, b) when the accumulator pulses valid. It packs PACK_N consecutive pairs into one wide word and buffers packed words in a small FIFO with a valid/ready output handshake. It drives `halt` back to the accumulator so that no result is lost under output back-pressure.

## Interface
Parameters:
- PACK_N, 4: pairs packed per output word (2..8)
- FIFO_DEPTH, 4: packed words buffered (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- usr_rst  in  1  synchronous soft clear, active-high
- in_data_a  in  16  accumulated sum a (signed two's complement)
- in_data_b  in  16  accumulated sum b (signed two's complement)
- in_v  in  1  one-cycle pulse, pair valid (accumulator out_data_v)
- halt  out  1  stall request to accumulator
- out_data  out  32*PACK_N  packed word, FIFO head
- out_v  out  1  FIFO non-empty
- out_rdy  in  1  consumer accepts head when out_v & out_rdy
- ovf  out  1  sticky: a pair was dropped
- fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Pack register: PACK_N×32 bits plus `pack_cnt` (0..PACK_N-1). Pair k is placed in bits [32k+15:32k] (a) and [32k+31:32k+16] (b).
- On in_v:
  - If pack_cnt < PACK_N-1: store the pair in slot pack_cnt and increment pack_cnt.
  - If pack_cnt == PACK_N-1 and the FIFO can push: the assembled word (with the current pair in the top slot) is pushed, pack_cnt wraps to 0, and the pack register is zeroed.
  - A push is possible when count < FIFO_DEPTH, or the FIFO is full and a pop occurs in the same cycle.
  - If no push is possible: the pair is dropped, pack_cnt and the partial word are held, and ovf is set.
- Pop when out_v & out_rdy. Simultaneous push and pop leaves count unchanged, at any occupancy including full.
- halt = (count == FIFO_DEPTH) | (count == FIFO_DEPTH-1 & pack_cnt == PACK_N-1). Combinational from registers only; it does not depend on out_rdy.
- ovf is cleared only by rst or usr_rst.
- usr_rst clears pack_cnt, the pack register, FIFO pointers/count and ovf. It overrides a same-cycle in_v and pop: the pair is discarded and the head is not popped.
- rst asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Timing
- Reset values: halt=0, out_v=0, out_data=0, ovf=0, fill=0.
- A final pair sampled at edge k is visible as out_v=1 with its word on out_data after edge k (1-cycle latency). out_data is first-word-fall-through from the FIFO head.
- A pop at edge k shows the next head, or out_v=0, after edge k.
- halt updates one cycle after the edge that changed count or pack_cnt.
- The accumulator produces at most 1 pair per 3 cycles, so the one-cycle halt response never causes ovf under legal upstream behaviour.
- fill reflects count after each edge.

## Configuration
- SELFADD_PACK_RELU_EN defined: each 16-bit sum is clamped before packing; if bit 15 is set, 16'h0000 is stored.
- Not defined: sums are packed unmodified.
- Slot positions and timing are identical in both cases.

## Structure
- Shared package `selfadd_pkg`:
  - DATA_W=16
  - PAIR_W=32
  - function computing FILL_W from FIFO_DEPTH
- One sub-module: `selfadd_word_fifo`, a synchronous FWFT FIFO with parameters WIDTH and DEPTH. It exposes push, pop, full, empty and count, and has async active-low reset plus a synchronous clear.
- Packing, ReLU and halt logic live in the top module.

## Test plan
- Reset/idle, PACK_N=4: after rst release, out_v=0, halt=0, fill=0, ovf=0.
- Basic packing, PACK_N=4: four pairs with (a,b) = (1,2), (3,4), (5,6), (7,8), each 3 cycles apart, out_rdy=1. Required: out_data = 128'h0008_0007_0006_0005_0004_0003_0002_0001; out_v high exactly 1 cycle.
- Back-pressure: hold out_rdy=0 and feed 16 pairs. Required:
  - fill reaches 4
  - halt asserts after fill=3 and pack_cnt=3
  - releasing out_rdy pops the words in order
- Overflow: with the FIFO full and out_rdy=0, feed 4 more pairs ignoring halt. Required: ovf=1, fill stays 4, pack_cnt frozen at 3. Then usr_rst gives fill=0 and ovf=0.
- Full push+pop: with fill=4, a final pair arrives in the same cycle as out_rdy=1. Required: fill stays 4, the new word sits at the tail, ovf=0.
- RELU, built with SELFADD_PACK_RELU_EN: pair (16'hFFFE, 16'h0005) packs as 32'h0005_0000. Built without the macro: it packs as 32'h0005_FFFE.
